// File: rtl/pe_db_mac.sv
// pe_db_mac: weight-stationary systolic processing element.
// Activations move east and partial sums move south, each with one
// register stage. Weights are double-buffered: a shadow register is
// loaded while the active weight keeps feeding the multiplier, and a
// swap promotes the shadow. The MAC runs signed or unsigned and can
// saturate or wrap. A sticky flag records any overflow.
module pe_db_mac #(
  parameter int COMPUTE_DATA_WIDTH     = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 16,
  parameter bit SATURATE               = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [COMPUTE_DATA_WIDTH-1:0]     act_in,
  input  logic [ACCUMULATOR_DATA_WIDTH-1:0] psum_in,
  input  logic                              w_load,
  input  logic [COMPUTE_DATA_WIDTH-1:0]     w_in,
  input  logic                              w_swap,
  input  logic                              signed_mode,
  input  logic                              acc_mode,
  input  logic                              acc_clr,
  output logic [COMPUTE_DATA_WIDTH-1:0]     act_out,
  output logic                              act_valid_out,
  output logic [ACCUMULATOR_DATA_WIDTH-1:0] psum_out,
  output logic                              psum_valid_out,
  output logic                              shadow_full,
  output logic                              sat_flag
);

  localparam int DW = COMPUTE_DATA_WIDTH;
  localparam int AW = ACCUMULATOR_DATA_WIDTH;

  // Clamp bounds for the two number systems.
  localparam logic [AW-1:0] S_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] S_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [AW-1:0] U_MAX = {AW{1'b1}};

  // Registered state.
  logic [DW-1:0] w_act_q, w_act_d;
  logic [DW-1:0] w_sh_q, w_sh_d;
  logic          sh_full_q, sh_full_d;
  logic [DW-1:0] act_q, act_d;
  logic          act_v_q, act_v_d;
  logic [AW-1:0] psum_q, psum_d;
  logic          psum_v_q, psum_v_d;
  logic          sat_q, sat_d;

  // MAC datapath signals, all carried at AW+1 bits so the carry or
  // sign-overflow bit is visible.
  logic [AW-1:0] base;
  logic [AW:0]   a_ext;
  logic [AW:0]   w_ext;
  logic [AW:0]   base_ext;
  logic [AW:0]   prod;
  logic [AW:0]   sum;
  logic          ovf;
  logic [AW-1:0] result;

  // MAC: extend operands, pick the accumulation base, add, detect overflow, clamp or wrap.
  always_comb begin
    base     = {AW{1'b0}};
    a_ext    = {(AW+1){1'b0}};
    w_ext    = {(AW+1){1'b0}};
    base_ext = {(AW+1){1'b0}};
    ovf      = 1'b0;
    result   = {AW{1'b0}};

    // Clear-then-accumulate: a same-cycle clear zeroes the base.
    if (acc_clr) begin
      base = {AW{1'b0}};
    end else if (acc_mode) begin
      base = psum_q;
    end else begin
      base = psum_in;
    end

    if (signed_mode) begin
      a_ext    = {{(AW+1-DW){act_in[DW-1]}}, act_in};
      w_ext    = {{(AW+1-DW){w_act_q[DW-1]}}, w_act_q};
      base_ext = {base[AW-1], base};
    end else begin
      a_ext    = {{(AW+1-DW){1'b0}}, act_in};
      w_ext    = {{(AW+1-DW){1'b0}}, w_act_q};
      base_ext = {1'b0, base};
    end

    // Product magnitude fits well inside AW bits, so the AW+1-bit
    // modular product equals the exact product in both modes.
    prod = a_ext * w_ext;
    sum  = base_ext + prod;

    if (signed_mode) begin
      ovf = sum[AW] ^ sum[AW-1];
    end else begin
      ovf = sum[AW];
    end

    if (ovf && SATURATE) begin
      if (signed_mode) begin
        result = sum[AW] ? S_MIN : S_MAX;
      end else begin
        // Unsigned operands cannot go below zero, so only the top clamps.
        result = U_MAX;
      end
    end else begin
      result = sum[AW-1:0];
    end
  end

  // Next-state for weights, pipelines, accumulator and sticky flag.
  always_comb begin
    w_act_d   = w_act_q;
    w_sh_d    = w_sh_q;
    sh_full_d = sh_full_q;
    act_d     = act_in;
    act_v_d   = in_valid;
    psum_d    = psum_q;
    psum_v_d  = in_valid;
    sat_d     = sat_q;

    // Swap first so a same-cycle load refills the shadow afterwards.
    if (w_swap && sh_full_q) begin
      w_act_d   = w_sh_q;
      sh_full_d = 1'b0;
    end else begin
      w_act_d = w_act_q;
    end

    if (w_load) begin
      w_sh_d    = w_in;
      sh_full_d = 1'b1;
    end else begin
      w_sh_d = w_sh_q;
    end

    if (in_valid) begin
      psum_d = result;
    end else if (acc_clr) begin
      psum_d = {AW{1'b0}};
    end else begin
      psum_d = psum_q;
    end

    // A fresh overflow wins over a same-cycle clear.
    if (in_valid && ovf) begin
      sat_d = 1'b1;
    end else if (acc_clr) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_act_q   <= {DW{1'b0}};
      w_sh_q    <= {DW{1'b0}};
      sh_full_q <= 1'b0;
      act_q     <= {DW{1'b0}};
      act_v_q   <= 1'b0;
      psum_q    <= {AW{1'b0}};
      psum_v_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      w_act_q   <= w_act_d;
      w_sh_q    <= w_sh_d;
      sh_full_q <= sh_full_d;
      act_q     <= act_d;
      act_v_q   <= act_v_d;
      psum_q    <= psum_d;
      psum_v_q  <= psum_v_d;
      sat_q     <= sat_d;
    end
  end

  assign act_out        = act_q;
  assign act_valid_out  = act_v_q;
  assign psum_out       = psum_q;
  assign psum_valid_out = psum_v_q;
  assign shadow_full    = sh_full_q;
  assign sat_flag       = sat_q;

endmodule

// File: tb/tb_pe_db_mac.sv
// Bench for pe_db_mac: a saturating and a wrapping instance share all
// inputs and are compared every cycle against an integer-arithmetic model.
module tb_pe_db_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  act_in = 4'd0;
  logic [15:0] psum_in = 16'd0;
  logic        w_load = 1'b0;
  logic [3:0]  w_in = 4'd0;
  logic        w_swap = 1'b0;
  logic        signed_mode = 1'b0;
  logic        acc_mode = 1'b0;
  logic        acc_clr = 1'b0;

  logic [3:0]  act_out_s, act_out_w;
  logic        act_v_s, act_v_w;
  logic [15:0] psum_s, psum_w;
  logic        psv_s, psv_w;
  logic        full_s, full_w;
  logic        sat_s, sat_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pe_db_mac #(.COMPUTE_DATA_WIDTH(4), .ACCUMULATOR_DATA_WIDTH(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .act_in(act_in), .psum_in(psum_in),
    .w_load(w_load), .w_in(w_in), .w_swap(w_swap), .signed_mode(signed_mode),
    .acc_mode(acc_mode), .acc_clr(acc_clr), .act_out(act_out_s), .act_valid_out(act_v_s),
    .psum_out(psum_s), .psum_valid_out(psv_s), .shadow_full(full_s), .sat_flag(sat_s));

  pe_db_mac #(.COMPUTE_DATA_WIDTH(4), .ACCUMULATOR_DATA_WIDTH(16), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .act_in(act_in), .psum_in(psum_in),
    .w_load(w_load), .w_in(w_in), .w_swap(w_swap), .signed_mode(signed_mode),
    .acc_mode(acc_mode), .acc_clr(acc_clr), .act_out(act_out_w), .act_valid_out(act_v_w),
    .psum_out(psum_w), .psum_valid_out(psv_w), .shadow_full(full_w), .sat_flag(sat_w));

  // ---------------- behavioural model ----------------
  int m_wa = 0, m_ws = 0, m_act = 0;
  bit m_full = 1'b0, m_actv = 1'b0, m_psv = 1'b0;
  int m_ps[2] = '{0, 0};
  bit m_flag[2] = '{1'b0, 1'b0};

  function automatic longint as_signed(longint v, int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  // True-value MAC; sat selects clamping, otherwise modulo 2^16.
  task automatic model_mac(input int base, input bit sgn, input bit sat,
                           output int res, output bit ovf);
    longint a, w, b, t;
    a = sgn ? as_signed(longint'(act_in), 4) : longint'(act_in);
    w = sgn ? as_signed(longint'(m_wa), 4) : longint'(m_wa);
    b = sgn ? as_signed(longint'(base), 16) : longint'(base);
    t = b + a * w;
    if (sgn) begin
      ovf = (t > 32767) || (t < -32768);
      if (ovf && sat) t = (t > 0) ? 32767 : -32768;
    end else begin
      ovf = (t > 65535);
      if (ovf && sat) t = 65535;
    end
    res = int'(t & 64'hFFFF);
  endtask

  // Model state update, same clock and reset as the design.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wa = 0; m_ws = 0; m_full = 1'b0; m_act = 0; m_actv = 1'b0; m_psv = 1'b0;
      m_ps[0] = 0; m_ps[1] = 0; m_flag[0] = 1'b0; m_flag[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        int base, res;
        bit ovf;
        base = acc_clr ? 0 : (acc_mode ? m_ps[k] : int'(psum_in));
        if (in_valid) begin
          model_mac(base, signed_mode, (k == 0), res, ovf);
          m_ps[k] = res;
          m_flag[k] = ovf ? 1'b1 : (acc_clr ? 1'b0 : m_flag[k]);
        end else if (acc_clr) begin
          m_ps[k] = 0;
          m_flag[k] = 1'b0;
        end
      end
      if (w_swap && m_full) begin
        m_wa = m_ws;
        m_full = 1'b0;
      end
      if (w_load) begin
        m_ws = int'(w_in);
        m_full = 1'b1;
      end
      m_act = int'(act_in);
      m_actv = in_valid;
      m_psv = in_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clk) begin
    chk("act_out_s", 32'(act_out_s), 32'(m_act));
    chk("act_out_w", 32'(act_out_w), 32'(m_act));
    chk("act_v_s", 32'(act_v_s), 32'(m_actv));
    chk("act_v_w", 32'(act_v_w), 32'(m_actv));
    chk("psum_v_s", 32'(psv_s), 32'(m_psv));
    chk("psum_v_w", 32'(psv_w), 32'(m_psv));
    chk("psum_s", 32'(psum_s), 32'(m_ps[0]));
    chk("psum_w", 32'(psum_w), 32'(m_ps[1]));
    chk("sat_s", 32'(sat_s), 32'(m_flag[0]));
    chk("sat_w", 32'(sat_w), 32'(m_flag[1]));
    chk("full_s", 32'(full_s), 32'(m_full));
    chk("full_w", 32'(full_w), 32'(m_full));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; w_load = 1'b0; w_swap = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic load_swap(input logic [3:0] w);
    idle();
    w_load = 1'b1; w_in = w; step();
    w_load = 1'b0; w_swap = 1'b1; step();
    w_swap = 1'b0;
  endtask

  task automatic mac(input logic [3:0] a, input logic [15:0] p);
    in_valid = 1'b1; act_in = a; psum_in = p; step();
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    chk("reset_psum", 32'(psum_s), 32'h0);
    chk("reset_full", 32'(full_s), 32'h0);

    // Load, swap, chain MAC.
    w_load = 1'b1; w_in = 4'd3; step();
    chk("load_full", 32'(full_s), 32'h1);
    w_load = 1'b0; w_swap = 1'b1; step();
    chk("swap_full", 32'(full_s), 32'h0);
    w_swap = 1'b0;
    acc_mode = 1'b0; signed_mode = 1'b0;
    mac(4'd5, 16'd10);
    chk("chain_psum", 32'(psum_s), 32'd25);
    chk("chain_pv", 32'(psv_s), 32'h1);
    chk("chain_act", 32'(act_out_s), 32'd5);

    // Signed vs unsigned.
    load_swap(4'hE);
    signed_mode = 1'b1; mac(4'hD, 16'd0);
    chk("signed_mul", 32'(psum_s), 32'd6);
    signed_mode = 1'b0; mac(4'hD, 16'd0);
    chk("unsigned_mul", 32'(psum_s), 32'd182);

    // Saturation and wrap.
    load_swap(4'd7);
    signed_mode = 1'b1; mac(4'd7, 16'h7FF0);
    chk("sat_signed", 32'(psum_s), 32'h7FFF);
    chk("sat_signed_flag", 32'(sat_s), 32'h1);
    chk("wrap_signed", 32'(psum_w), 32'h8021);
    signed_mode = 1'b0; mac(4'd7, 16'hFFF0);
    chk("sat_unsigned", 32'(psum_s), 32'hFFFF);
    chk("wrap_unsigned", 32'(psum_w), 32'h0021);
    chk("wrap_flag", 32'(sat_w), 32'h1);
    idle(); acc_clr = 1'b1; step();
    chk("clr_flag", 32'(sat_s), 32'h0);
    chk("clr_psum", 32'(psum_s), 32'h0);
    acc_clr = 1'b0;

    // Swap with empty shadow is ignored.
    w_swap = 1'b1; mac(4'd1, 16'd0);
    chk("empty_swap", 32'(psum_s), 32'd7);
    w_swap = 1'b0;

    // Same-cycle load and swap.
    idle(); w_load = 1'b1; w_in = 4'd2; step();
    w_in = 4'd9; w_swap = 1'b1; mac(4'd1, 16'd0);
    chk("ls_old_w", 32'(psum_s), 32'd7);
    w_load = 1'b0; w_swap = 1'b0; mac(4'd1, 16'd0);
    chk("ls_new_w", 32'(psum_s), 32'd2);
    chk("ls_full", 32'(full_s), 32'h1);
    w_swap = 1'b1; mac(4'd1, 16'd0);
    w_swap = 1'b0; mac(4'd1, 16'd0);
    chk("ls_shadow9", 32'(psum_s), 32'd9);

    // Local accumulate with clear.
    load_swap(4'd2);
    acc_clr = 1'b1; step(); acc_clr = 1'b0;
    acc_mode = 1'b1;
    mac(4'd1, 16'h1234); chk("local1", 32'(psum_s), 32'd2);
    mac(4'd2, 16'h1234); chk("local2", 32'(psum_s), 32'd6);
    mac(4'd3, 16'h1234); chk("local3", 32'(psum_s), 32'd12);
    acc_clr = 1'b1; mac(4'd4, 16'h1234);
    chk("local_clr", 32'(psum_s), 32'd8);
    chk("local_clr_flag", 32'(sat_s), 32'h0);
    idle(); acc_mode = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int sel;
      in_valid = ($urandom_range(0, 3) != 0);
      act_in = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 3);
      case (sel)
        0: psum_in = 16'($urandom_range(16'h7FC0, 16'h7FFF));
        1: psum_in = 16'($urandom_range(16'hFFC0, 16'hFFFF));
        2: psum_in = 16'($urandom_range(16'h8000, 16'h803F));
        default: psum_in = 16'($urandom_range(0, 16'hFFFF));
      endcase
      w_load = ($urandom_range(0, 3) == 0);
      w_in = 4'($urandom_range(0, 15));
      w_swap = ($urandom_range(0, 3) == 0);
      signed_mode = 1'($urandom_range(0, 1));
      acc_mode = 1'($urandom_range(0, 1));
      acc_clr = ($urandom_range(0, 9) == 0);
      step();
    end

    // Reset during traffic.
    idle(); acc_mode = 1'b0;
    load_swap(4'd3);
    for (int i = 0; i < 4; i++) mac(4'h5, 16'h0100);
    #2 rst = 1'b0;
    #1;
    chk("rst_psum", 32'(psum_s), 32'h0);
    chk("rst_pv", 32'(psv_s), 32'h0);
    chk("rst_act", 32'(act_out_s), 32'h0);
    chk("rst_av", 32'(act_v_s), 32'h0);
    chk("rst_full", 32'(full_s), 32'h0);
    chk("rst_sat", 32'(sat_s), 32'h0);
    step(); step();
    chk("rst_hold_psum", 32'(psum_s), 32'h0);
    chk("rst_hold_av", 32'(act_v_s), 32'h0);
    rst = 1'b1;
    mac(4'h5, 16'h0100);
    chk("post_rst_w0", 32'(psum_s), 32'h0100);
    idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_db_mac.md
Name: pe_db_mac

Overview:
- Weight-stationary systolic processing element.
- Successor to the single-weight PE. Adds:
  - double-buffered weights, so the next tile's weights load while the current tile computes;
  - parametrised signed/unsigned MAC;
  - selectable chain-mode or local-accumulate mode;
  - saturating accumulation with a sticky overflow flag;
  - valid-qualified activation and partial-sum pipelines.
- Instantiated in a 2-D grid: activations flow east, partial sums flow south.

Parameters:
- COMPUTE_DATA_WIDTH, 4, activation/weight width (DW).
- ACCUMULATOR_DATA_WIDTH, 16, partial-sum/accumulator width (AW); must be >= 2*DW.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  act_in/psum_in qualify a MAC this cycle.
- act_in  input  DW  activation from west neighbour.
- psum_in  input  AW  partial sum from north neighbour.
- w_load  input  1  write w_in into the shadow weight register.
- w_in  input  DW  weight load data.
- w_swap  input  1  promote shadow weight to active.
- signed_mode  input  1  1 = two's-complement operands and accumulator, 0 = unsigned.
- acc_mode  input  1  0 = chain (base = psum_in), 1 = local (base = psum_out).
- acc_clr  input  1  synchronous clear of psum_out and sat_flag.
- act_out  output  DW  registered act_in to east neighbour.
- act_valid_out  output  1  registered in_valid.
- psum_out  output  AW  registered MAC result / accumulator.
- psum_valid_out  output  1  registered in_valid.
- shadow_full  output  1  shadow holds a weight not yet swapped in.
- sat_flag  output  1  sticky overflow indicator.

Behaviour:
- Reset (rst = 0, asynchronous):
  - All registers clear immediately: active weight, shadow weight, shadow_full, act_out, act_valid_out, psum_out, psum_valid_out, sat_flag are all 0.
  - Reset mid-operation discards everything; no state survives.
- Activation pipe, every cycle, no stall:
  - act_out <= act_in.
  - act_valid_out <= in_valid.
  - Latency 1.
- Weight buffer:
  - w_load = 1: shadow <= w_in, shadow_full <= 1.
  - w_swap = 1 with shadow_full = 1: active <= shadow, shadow_full <= 0.
  - w_swap = 1 with shadow_full = 0: ignored; active unchanged.
  - w_load and w_swap in the same cycle: active <= old shadow (only if shadow_full was 1), shadow <= w_in, shadow_full stays 1.
  - A MAC in the swap cycle uses the old active weight; the new weight applies from the next cycle.
- MAC, when in_valid = 1:
  - prod = act_in * active weight, 2*DW bits.
  - signed_mode = 1: signed multiply, sign-extended to AW. signed_mode = 0: zero-extended. Sampled per cycle.
  - base = psum_in (acc_mode = 0) or psum_out (acc_mode = 1). If acc_clr = 1 in the same cycle, base = 0 (clear-then-accumulate).
  - sum is computed at AW+1 bits.
  - Overflow, signed mode: result outside [-2^(AW-1), 2^(AW-1)-1].
  - Overflow, unsigned mode: carry out of AW.
  - SATURATE = 1: on overflow, clamp to the nearest bound (signed max/min, unsigned max or 0).
  - SATURATE = 0: keep the low AW bits.
  - Any overflow sets sat_flag. sat_flag stays set until acc_clr or reset.
  - psum_out <= result; psum_valid_out <= 1. Latency 1.
- in_valid = 0:
  - psum_out holds its value; psum_valid_out <= 0.
  - acc_clr still clears psum_out and sat_flag.
- acc_clr together with an overflowing MAC: sat_flag is set by the new MAC. Set has priority over clear.
- No combinational input-to-output paths.

Test Plan:
- Reset during traffic: drive in_valid = 1, act_in = 4'h5, psum_in = 16'h0100 for several cycles, then pull rst low mid-cycle → all outputs read 0 before the next clock edge; they stay 0 while rst = 0.
- Load/swap/chain MAC:
  - w_load w_in = 3, then w_swap → shadow_full goes 1, then 0.
  - act_in = 5, psum_in = 10, acc_mode = 0, signed_mode = 0 → next cycle psum_out = 25, psum_valid_out = 1, act_out = 5.
- Signed vs unsigned: active weight = 4'hE, act_in = 4'hD, psum_in = 0.
  - signed_mode = 1 → psum_out = 6.
  - signed_mode = 0 → psum_out = 182 (16'h00B6).
- Saturation, weight = 7, act_in = 7, SATURATE = 1:
  - Signed, psum_in = 16'h7FF0 → psum_out = 16'h7FFF, sat_flag = 1.
  - Unsigned, psum_in = 16'hFFF0 → psum_out = 16'hFFFF.
  - Same stimulus with SATURATE = 0 → psum_out = 16'h0021, sat_flag = 1.
- Weight buffer edge cases:
  - w_swap with shadow_full = 0 → MAC still uses the old weight.
  - Same-cycle w_load 9 and w_swap with shadow = 2 → MAC in that cycle uses the old weight; next cycle uses 2; shadow = 9, shadow_full = 1.
- Local accumulate with clear:
  - acc_mode = 1, weight = 2, act_in = 1,2,3 → psum_out = 2, 6, 12.
  - acc_clr together with act_in = 4 → psum_out = 8, sat_flag = 0.
